sram_param: RTL

Parametrised single-port synchronous SRAM model for the BIST flow; the successor to the fixed 256x4 array. It adds width, depth and init-value parameters, a post-reset clear sequencer with a `ready` flag, and a registered read with a valid strobe. It also provides a run-time fault-injection port (stuck-at and transition faults on one cell bit), so the BIST controller can be checked against known-bad memory. It sits between the BIST controller/functional mux and nothing else; it is the memory under test.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_fault_inj.sv | 44 ++++
 rtl/sram_param.sv | 111 +++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types for the parametrised SRAM model and its fault-injection helper.
package sram_pkg;

  typedef enum logic {
    INIT,
    READY
  } sram_state_e;

  typedef enum logic [1:0] {
    FT_NONE,
    FT_STUCK,
    FT_TRANS,
    FT_RSVD
  } fault_type_e;

endpackage

// File: rtl/sram_fault_inj.sv
// Combinational fault injection for one bit of one word: a stuck-at override on
// the read path and a blocked 0->1 transition on the write path.
module sram_fault_inj
  import sram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              active,
  input  logic [1:0]        fault_type,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic [BIT_W-1:0]  fault_bit,
  input  logic              fault_val,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] stored,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  fault_type_e ft;
  logic        hit;

  // Stuck-at only bends the returned data, so the stored word stays clean and
  // the fault disappears as soon as the injection is switched off. A transition
  // fault keeps a stored 0 at 0: the new bit is the AND of old and new.
  always_comb begin
    ft      = fault_type_e'(fault_type);
    hit     = active && (address == fault_addr) && ({1'b0, fault_addr} < DEPTH_L);
    wr_data = data_in;
    rd_data = stored;
    if (hit && (ft == FT_STUCK)) begin
      rd_data[fault_bit] = fault_val;
    end
    if (hit && (ft == FT_TRANS)) begin
      wr_data[fault_bit] = stored[fault_bit] & data_in[fault_bit];
    end
  end

endmodule

// File: rtl/sram_param.sv
// Parametrised single-port synchronous SRAM for BIST: clears itself to INIT_VAL
// after reset, then serves read-first accesses with a one-cycle registered read.
module sram_param
  import sram_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              ready,
  input  logic [1:0]        fault_type,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic [BIT_W-1:0]  fault_bit,
  input  logic              fault_val
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  sram_state_e       state, next_state;
  logic [ADDR_W-1:0] cnt, next_cnt;
  logic              in_range;
  logic              active;
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  assign in_range = ({1'b0, address} < DEPTH_L);
  assign active   = (state == READY);
  assign stored   = in_range ? mem[address] : '0;
  assign ready    = active;

  sram_fault_inj #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BIT_W  (BIT_W)
  ) u_fault (
    .active     (active),
    .fault_type (fault_type),
    .fault_addr (fault_addr),
    .fault_bit  (fault_bit),
    .fault_val  (fault_val),
    .address    (address),
    .stored     (stored),
    .data_in    (data_in),
    .wr_data    (wr_data),
    .rd_data    (rd_data)
  );

  // State and clear-counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Clear sequencer: walk every word once, then hand over to normal operation.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (state == INIT) begin
      next_cnt = cnt + ADDR_W'(1);
      if (cnt == LAST_ADDR) begin
        next_state = READY;
        next_cnt   = '0;
      end
    end
  end

  // Array write port: clear pattern during INIT, user writes once ready.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[cnt] <= INIT_VAL;
      end else if (we && in_range) begin
        mem[address] <= wr_data;
      end
    end
  end

  // Registered read; sees the pre-write word, so same-address access is read-first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else if (active && re) begin
      data_out <= in_range ? rd_data : '0;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule
